pak_dsp_rif: RTL

Register-interface and configuration scheduler for the pak-dsp core. It holds a shadow copy of the DUC/DDC bypass bits and filter coefficients, written and read over a valid/ready config channel. On a commit it waits until both datapaths are idle, then swaps shadow into active in a single cycle. Sits beside `duc`/`ddc` in `pak_dsp` and drives their `bypass` and `coeffs` ports.

---
 rtl/pak_dsp_rif.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pak_dsp_rif.sv
// pak_dsp_rif: register interface and configuration scheduler for pak-dsp.
// It holds shadow copies of the DUC/DDC bypass bits and the filter
// coefficients, reached over a valid/ready config channel. A commit waits
// until both datapaths are idle, then copies shadow into active in one cycle.
//
// Ports:
//   clk, arst_n            clock, synchronous active-low reset
//   cfg_valid_in/ready_out request handshake; cfg_wr_in, cfg_addr_in, cfg_wdata_in
//   rsp_valid_out/ready_in response handshake; rsp_rdata_out, rsp_err_out
//   dp_busy_in             bit0 DUC busy, bit1 DDC busy
//   bypass_duc_out/ddc_out active bypass bits
//   coeffs_out             active coefficients, coeff k at [k*COEFF_WIDTH +: COEFF_WIDTH]
//   swap_done_out          one-cycle pulse when active is updated
//
// Register map: 0x00 CTRL, 0x01 STATUS, 0x10.. shadow coefficients.
// Build option: define PAK_DSP_RIF_TIMEOUT_EN to force the swap after
// TIMEOUT_CYCLES busy cycles in WAIT (sets sticky STATUS bit3).
module pak_dsp_rif #(
  parameter int unsigned COEFF_WIDTH    = 16,
  parameter int unsigned N_COEFFS       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            arst_n,
  input  logic                            cfg_valid_in,
  output logic                            cfg_ready_out,
  input  logic                            cfg_wr_in,
  input  logic [7:0]                      cfg_addr_in,
  input  logic [31:0]                     cfg_wdata_in,
  output logic                            rsp_valid_out,
  input  logic                            rsp_ready_in,
  output logic [31:0]                     rsp_rdata_out,
  output logic                            rsp_err_out,
  input  logic [1:0]                      dp_busy_in,
  output logic                            bypass_duc_out,
  output logic                            bypass_ddc_out,
  output logic [N_COEFFS*COEFF_WIDTH-1:0] coeffs_out,
  output logic                            swap_done_out
);

  localparam int unsigned IDX_W     = (N_COEFFS > 1) ? $clog2(N_COEFFS) : 1;
  localparam logic [8:0]  COEFF_LIM = 9'(N_COEFFS);

  if (N_COEFFS < 1 || N_COEFFS > 64 || COEFF_WIDTH < 1 || COEFF_WIDTH > 32
      || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("pak_dsp_rif: parameter out of range");
  end

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                 state;
  logic [1:0]             shadow_byp;
  logic [COEFF_WIDTH-1:0] shadow_coeff [N_COEFFS];
  logic                   timeout_flag;

  logic                   accept;
  logic                   sel_ctrl, sel_status, sel_coeff, req_err;
  logic [7:0]             coeff_off;
  logic [IDX_W-1:0]       coeff_idx;
  logic [31:0]            rd_data;
  logic                   force_swap, swap_now;
  logic                   unused_wdata;

  assign cfg_ready_out = !rsp_valid_out;
  assign accept        = cfg_valid_in && cfg_ready_out;
  assign unused_wdata  = &{1'b0, cfg_wdata_in};

`ifdef PAK_DSP_RIF_TIMEOUT_EN
  logic [31:0] to_cnt;

  assign force_swap = (state == ST_WAIT) && (dp_busy_in != 2'b00)
                      && (to_cnt == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      to_cnt <= '0;
    end else if (accept && cfg_wr_in && !req_err && sel_ctrl && cfg_wdata_in[8]) begin
      to_cnt <= '0;
    end else if (state == ST_WAIT && dp_busy_in != 2'b00 && !force_swap) begin
      to_cnt <= to_cnt + 32'd1;
    end
  end
`else
  assign force_swap = 1'b0;
`endif

  assign swap_now = (state == ST_WAIT) && ((dp_busy_in == 2'b00) || force_swap);

  always_comb begin
    coeff_off  = cfg_addr_in - 8'h10;
    coeff_idx  = coeff_off[IDX_W-1:0];
    sel_ctrl   = (cfg_addr_in == 8'h00);
    sel_status = (cfg_addr_in == 8'h01);
    sel_coeff  = (cfg_addr_in >= 8'h10) && ({1'b0, coeff_off} < COEFF_LIM);
    // Shadow state is frozen while a commit is pending; STATUS stays writable.
    req_err    = !(sel_ctrl || sel_status || sel_coeff)
                 || (cfg_wr_in && state == ST_WAIT && (sel_ctrl || sel_coeff));
    rd_data    = '0;
    if (!cfg_wr_in && !req_err) begin
      if (sel_ctrl) begin
        rd_data[1:0] = shadow_byp;
      end else if (sel_status) begin
        rd_data[3:0] = {timeout_flag, dp_busy_in, state == ST_WAIT};
      end else begin
        rd_data[COEFF_WIDTH-1:0] = shadow_coeff[coeff_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state          <= ST_IDLE;
      shadow_byp     <= '0;
      timeout_flag   <= 1'b0;
      rsp_valid_out  <= 1'b0;
      rsp_rdata_out  <= '0;
      rsp_err_out    <= 1'b0;
      bypass_duc_out <= 1'b1;
      bypass_ddc_out <= 1'b1;
      coeffs_out     <= '0;
      swap_done_out  <= 1'b0;
      for (int unsigned k = 0; k < N_COEFFS; k++) begin
        shadow_coeff[IDX_W'(k)] <= '0;
      end
    end else begin
      swap_done_out <= 1'b0;

      if (rsp_valid_out && rsp_ready_in) begin
        rsp_valid_out <= 1'b0;
      end

      if (accept) begin
        rsp_valid_out <= 1'b1;
        rsp_rdata_out <= rd_data;
        rsp_err_out   <= req_err;
        if (cfg_wr_in && !req_err) begin
          if (sel_ctrl) begin
            shadow_byp <= cfg_wdata_in[1:0];
            if (cfg_wdata_in[8]) begin
              state <= ST_WAIT;
            end
          end
          if (sel_status && cfg_wdata_in[3]) begin
            timeout_flag <= 1'b0;
          end
          if (sel_coeff) begin
            shadow_coeff[coeff_idx] <= cfg_wdata_in[COEFF_WIDTH-1:0];
          end
        end
      end

      // Commits are only accepted in IDLE and swaps only occur in WAIT,
      // so the two state updates never collide.
      if (swap_now) begin
        bypass_duc_out <= shadow_byp[0];
        bypass_ddc_out <= shadow_byp[1];
        for (int unsigned k = 0; k < N_COEFFS; k++) begin
          coeffs_out[k*COEFF_WIDTH +: COEFF_WIDTH] <= shadow_coeff[IDX_W'(k)];
        end
        swap_done_out <= 1'b1;
        state         <= ST_IDLE;
        if (force_swap) begin
          timeout_flag <= 1'b1;
        end
      end
    end
  end

endmodule
